rsa_exp_ctrl: RTL and testbench

RSA_EXP_CTRL -- requirements
Module: rsa_exp_ctrl

---
 rtl/rsa_exp_ctrl.sv | 109 ++++++++++
 tb/tb_rsa_exp_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rsa_exp_ctrl.sv
// rsa_exp_ctrl: left-to-right square-and-multiply sequencer driving an external modular multiplier.
// Define RSA_EXP_LZ_SKIP_EN to skip leading zero exponent bits in a SCAN state.
module rsa_exp_ctrl #(
  parameter int WIDTH = 128,
  parameter int EXP_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] modulus,
  input  logic [EXP_W-1:0] exponent,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_n,
  input  logic             mm_done,
  input  logic [WIDTH-1:0] mm_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int IW = $clog2(EXP_W);
  localparam logic [IW-1:0] TOP = IW'(EXP_W - 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  typedef enum logic [2:0] {IDLE, SCAN, SQ, SQ_WAIT, MUL, MUL_WAIT, NEXT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] acc, b_q, n_q;
  logic [EXP_W-1:0] e_q;
  logic [IW-1:0] idx;
  assign mm_n = n_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= ONE;
      idx      <= TOP;
      b_q      <= '0;
      n_q      <= '0;
      e_q      <= '0;
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      mm_start <= 1'b0;
      done     <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start && !abort) begin
            b_q   <= base;
            n_q   <= modulus;
            e_q   <= exponent;
            acc   <= ONE;
            idx   <= TOP;
            busy  <= 1'b1;
`ifdef RSA_EXP_LZ_SKIP_EN
            state <= SCAN;
`else
            state <= SQ;
`endif
          end
          SCAN: begin
            // e==0 leaves acc at 1 and finishes without touching the multiplier
            if (e_q == '0) state <= DONE;
            else if (e_q[idx]) state <= SQ;
            else idx <= idx - 1'b1;
          end
          SQ: begin
            mm_start <= 1'b1;
            mm_a     <= acc;
            mm_b     <= acc;
            state    <= SQ_WAIT;
          end
          SQ_WAIT: if (mm_done) begin
            acc   <= mm_result;
            state <= e_q[idx] ? MUL : NEXT;
          end
          MUL: begin
            mm_start <= 1'b1;
            mm_a     <= acc;
            mm_b     <= b_q;
            state    <= MUL_WAIT;
          end
          MUL_WAIT: if (mm_done) begin
            acc   <= mm_result;
            state <= NEXT;
          end
          NEXT: begin
            state <= (idx == '0) ? DONE : SQ;
            idx   <= (idx == '0) ? idx : idx - 1'b1;
          end
          DONE: begin
            done   <= 1'b1;
            result <= acc;
            busy   <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// tb_rsa_exp_ctrl: scoreboard bench with a 3-cycle stub modular multiplier.
module tb_rsa_exp_ctrl;
  localparam int W = 128, E = 32;
  logic clk = 0, reset = 0, start = 0, abort = 0, mm_done = 0;
  logic mm_start, busy, done;
  logic [W-1:0] base = 0, modulus = 0, mm_result = 0;
  logic [W-1:0] mm_a, mm_b, mm_n, result;
  logic [E-1:0] exponent = 0;
  int n_cmp = 0, n_err = 0, n_starts = 0, cnt = 0;
  logic [255:0] pa = 0, pb = 0, pn = 1;
  logic [W-1:0] sb[$];
  logic [W-1:0] last_exp = 0, popped;

  rsa_exp_ctrl #(.WIDTH(W), .EXP_W(E)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .base(base), .modulus(modulus),
    .exponent(exponent), .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
    .mm_done(mm_done), .mm_result(mm_result), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] gold(input logic [W-1:0] b, input logic [W-1:0] n, input logic [E-1:0] e);
    logic [255:0] r, x;
    r = 256'd1 % 256'(n);
    x = 256'(b) % 256'(n);
    for (int i = 0; i < E; i++) begin
      if (e[i]) r = (r * x) % 256'(n);
      x = (x * x) % 256'(n);
    end
    return r[W-1:0];
  endfunction

  always @(posedge clk) begin
    mm_done <= 1'b0;
    if (mm_start) begin
      n_starts++;
      chk("mm_overlap", W'(cnt), 0);
    end
    if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        mm_done   <= 1'b1;
        mm_result <= W'((pa * pb) % pn);
      end
    end else if (mm_start) begin
      pa  <= 256'(mm_a);
      pb  <= 256'(mm_b);
      pn  <= 256'(mm_n);
      cnt <= 3;
    end
  end

  always @(negedge clk) begin
    if (cnt != 0 && busy) begin
      chk("mm_a_hold", mm_a, pa[W-1:0]);
      chk("mm_b_hold", mm_b, pb[W-1:0]);
      chk("mm_n_hold", mm_n, pn[W-1:0]);
    end
    if (done) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        popped = sb.pop_front();
        chk("result", result, popped);
      end
    end
  end

  task automatic run(input logic [W-1:0] b, input logic [W-1:0] n, input logic [E-1:0] e, input bit poke);
    int lat, nsq;
    nsq = E;
`ifdef RSA_EXP_LZ_SKIP_EN
    nsq = 0;
    for (int i = 0; i < E; i++) if (e[i]) nsq = i + 1;
`endif
    last_exp = gold(b, n, e);
    sb.push_back(last_exp);
    base = b; modulus = n; exponent = e; start = 1; n_starts = 0;
    @(negedge clk);
    start = 0; lat = 0;
    while (!done && lat < 4000) begin
      start = 0;
      if (poke && lat == 20) begin
        chk("busy_mid", W'(busy), 1);
        base = ~b; modulus = n + 2; exponent = 0; start = 1;
      end
      @(negedge clk);
      lat++;
    end
    start = 0;
    chk("timeout", W'(lat >= 4000), 0);
`ifdef RSA_EXP_LZ_SKIP_EN
    if (e == 0) chk("lz_latency", W'(lat), 2);
`endif
    @(negedge clk);
    chk("done_once", W'(done), 0);
    chk("mm_starts", W'(n_starts), W'(nsq + $countones(e)));
    chk("busy_after", W'(busy), 0);
    chk("sb_empty", W'(sb.size()), 0);
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), 0);
    chk("rst_done", W'(done), 0);
    chk("rst_mm_start", W'(mm_start), 0);
    chk("rst_result", result, 0);
    chk("rst_mm_n", mm_n, 0);
    reset = 1;
    @(negedge clk);
    chk("idle_busy", W'(busy), 0);

    run(4, 497, 13, 0);
    chk("r445", result, 445);
    run(7, 11, 0, 0);
    chk("r1", result, 1);
    run(2, 1000003, '1, 1);

    start = 1; abort = 1; base = 9; modulus = 1000; exponent = 5;
    @(negedge clk);
    start = 0; abort = 0;
    chk("start_abort_busy", W'(busy), 0);

    base = 9; modulus = 1000; exponent = 32'hF0F0_0000; start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", W'(busy), 0);
    repeat (12) begin
      chk("abort_no_done", W'(done), 0);
      @(negedge clk);
    end
    chk("abort_result", result, last_exp);
    run(3, 7, 5, 0);
    chk("r5", result, 5);

    base = 6; modulus = 1000; exponent = 32'h8000_0001; start = 1; n_starts = 0;
    @(negedge clk);
    start = 0; lat = 0;
    while (n_starts < 2 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("mul_wait_timeout", W'(lat >= 100), 0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("mid_rst_busy", W'(busy), 0);
    chk("mid_rst_done", W'(done), 0);
    chk("mid_rst_mm_start", W'(mm_start), 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_mm_n", mm_n, 0);
    @(negedge clk);
    reset = 1;
    repeat (10) begin
      chk("rst_no_done", W'(done), 0);
      @(negedge clk);
    end
    run(5, 23, 3, 0);
    chk("r10", result, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
